// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit pipelined core:
// opcodes, instruction field positions and fetch FSM states.
package cpu_pkg;

    localparam logic [3:0] OP_NOP   = 4'b0000;
    localparam logic [3:0] OP_ADD   = 4'b0001;
    localparam logic [3:0] OP_SUB   = 4'b0010;
    localparam logic [3:0] OP_AND   = 4'b0011;
    localparam logic [3:0] OP_OR    = 4'b0100;
    localparam logic [3:0] OP_XOR   = 4'b0101;
    localparam logic [3:0] OP_ADDI  = 4'b0110;
    localparam logic [3:0] OP_LOAD  = 4'b0111;
    localparam logic [3:0] OP_STORE = 4'b1000;
    localparam logic [3:0] OP_BEQ   = 4'b1001;
    localparam logic [3:0] OP_BNE   = 4'b1010;
    localparam logic [3:0] OP_JUMP  = 4'b1111;

    localparam int OP_HI  = 23;
    localparam int OP_LO  = 20;
    localparam int RD_HI  = 19;
    localparam int RD_LO  = 16;
    localparam int RS1_HI = 15;
    localparam int RS1_LO = 12;
    localparam int RS2_HI = 11;
    localparam int RS2_LO = 8;
    localparam int IMM_HI = 15;
    localparam int IMM_LO = 0;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } fetch_state_t;

    localparam logic [23:0] BUBBLE = 24'h000000;

endpackage

// File: rtl/fetch_stage_if_id_register.sv
// IF/ID pipeline register: instruction word, PC+1 and valid flag,
// with flush-to-bubble, stall-hold and asynchronous clear.
module if_id_register
    import cpu_pkg::*;
#(
    parameter int PCWIDTH          = 16,
    parameter int INSTRUCTIONWIDTH = 24
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        i_flush,
    input  logic                        i_stall,
    input  logic [INSTRUCTIONWIDTH-1:0] i_instr,
    input  logic [PCWIDTH-1:0]          i_pc_plus1,
    output logic [INSTRUCTIONWIDTH-1:0] o_instr,
    output logic [PCWIDTH-1:0]          o_pc_plus1,
    output logic                        o_valid
);

    logic [INSTRUCTIONWIDTH-1:0] r_instr;
    logic [PCWIDTH-1:0]          r_pc_plus1;
    logic                        r_valid;

    // A bubble keeps the old PC+1; only the word and valid are cleared.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_instr    <= '0;
            r_pc_plus1 <= '0;
            r_valid    <= 1'b0;
        end else if (i_flush) begin
            r_instr <= INSTRUCTIONWIDTH'(BUBBLE);
            r_valid <= 1'b0;
        end else if (!i_stall) begin
            r_instr    <= i_instr;
            r_pc_plus1 <= i_pc_plus1;
            r_valid    <= 1'b1;
        end
    end

    assign o_instr    = r_instr;
    assign o_pc_plus1 = r_pc_plus1;
    assign o_valid    = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: run/idle FSM, program counter,
// delivered-instruction counter and the IF/ID register.
module fetch_stage
    import cpu_pkg::*;
#(
    parameter int PCWIDTH          = 16,
    parameter int INSTRUCTIONWIDTH = 24,
    parameter int OPCODEWIDTH      = 4,
    parameter int ADDRESSWIDTH     = 4
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        start,
    input  logic                        halt,
    input  logic                        stallF,
    input  logic                        stallD,
    input  logic                        flushD,
    input  logic                        branchTakenE,
    input  logic [PCWIDTH-1:0]          branchTargetE,
    output logic [PCWIDTH-1:0]          instrAddrF,
    input  logic [INSTRUCTIONWIDTH-1:0] instrF,
    output logic [INSTRUCTIONWIDTH-1:0] instructionD,
    output logic [OPCODEWIDTH-1:0]      opcodeD,
    output logic [ADDRESSWIDTH-1:0]     rdD,
    output logic [ADDRESSWIDTH-1:0]     rs1D,
    output logic [ADDRESSWIDTH-1:0]     rs2D,
    output logic [15:0]                 immD,
    output logic [PCWIDTH-1:0]          pcPlus1D,
    output logic                        validD,
    output logic [15:0]                 fetchCount,
    output logic                        running
);

    fetch_state_t        r_state;
    logic [PCWIDTH-1:0]  r_pc;
    logic [15:0]         r_fetch_count;
    logic                r_running;

    logic                w_run;
    logic                w_bubble;
    logic                w_load_valid;
    logic [PCWIDTH-1:0]  w_pc_plus1;

    assign w_run        = (r_state == RUN);
    assign w_bubble     = flushD || branchTakenE || !w_run;
    assign w_load_valid = !w_bubble && !stallD;
    assign w_pc_plus1   = r_pc + PCWIDTH'(1);

    // Halt is checked before the redirect so halt+branch freezes the PC.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state       <= IDLE;
            r_pc          <= '0;
            r_fetch_count <= '0;
            r_running     <= 1'b0;
        end else begin
            if (w_load_valid)
                r_fetch_count <= r_fetch_count + 16'd1;
            unique case (r_state)
                IDLE: begin
                    if (start && !halt) begin
                        r_state   <= RUN;
                        r_running <= 1'b1;
                        r_pc      <= '0;
                    end
                end
                RUN: begin
                    if (halt) begin
                        r_state   <= IDLE;
                        r_running <= 1'b0;
                    end else if (branchTakenE) begin
                        r_pc <= branchTargetE;
                    end else if (!stallF) begin
                        r_pc <= w_pc_plus1;
                    end
                end
                default: ;
            endcase
        end
    end

    if_id_register #(
        .PCWIDTH         (PCWIDTH),
        .INSTRUCTIONWIDTH(INSTRUCTIONWIDTH)
    ) u_if_id (
        .clk       (clk),
        .rst       (rst),
        .i_flush   (w_bubble),
        .i_stall   (stallD),
        .i_instr   (instrF),
        .i_pc_plus1(w_pc_plus1),
        .o_instr   (instructionD),
        .o_pc_plus1(pcPlus1D),
        .o_valid   (validD)
    );

    assign instrAddrF = r_pc;
    assign opcodeD    = instructionD[OP_HI:OP_LO];
    assign rdD        = instructionD[RD_HI:RD_LO];
    assign rs1D       = instructionD[RS1_HI:RS1_LO];
    assign rs2D       = instructionD[RS2_HI:RS2_LO];
    assign immD       = instructionD[IMM_HI:IMM_LO];
    assign fetchCount = r_fetch_count;
    assign running    = r_running;

endmodule
